adc_trigger_capture: RTL

//  Consumes the deserialized per-channel ADC sample stream and records one DEPTH-sample window around a threshold trigger.

---
 rtl/adc_trigger_capture.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/adc_trigger_capture.sv
// Records one DEPTH-sample window around a threshold crossing or forced trigger, then streams it out.
// Latency: first rd_valid two cycles after READOUT entry, then one sample per cycle while rd_ready is high.
// Backpressure: rd_ready low holds rd_data/rd_last stable; input samples are dropped outside the capture states.
module adc_trigger_capture #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int PRETRIG    = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  trig_falling,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic [2:0]            state,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  // Terminal counts: the transition happens on the write that completes each phase.
  localparam logic [CNT_W-1:0]      PRE_LAST  = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0]      POST_LAST = CNT_W'(DEPTH - PRETRIG - 2);
  localparam logic [CNT_W-1:0]      RD_LAST   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      RD_TOTAL  = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PRE_OFS   = ADDR_WIDTH'(PRETRIG);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t st;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] trig_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      fill_cnt;
  logic [CNT_W-1:0]      post_cnt;
  logic [CNT_W-1:0]      rd_cnt;
  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_ok;
  logic                  ro_wait;

  logic capturing;
  logic wr_en;
  logic rise_hit;
  logic fall_hit;
  logic trig_hit;
  logic rd_xfer;
  logic rd_fetch;

  assign state = st;

  // Every valid sample is written while a capture is in progress.
  assign capturing = (st == S_PREFILL) || (st == S_ARMED) || (st == S_POST);
  assign wr_en     = capturing && sample_valid;

  // Crossing detection needs a previous sample from this capture; force wins without one.
  assign rise_hit = prev_ok && (prev <  threshold) && (sample_in >= threshold);
  assign fall_hit = prev_ok && (prev >= threshold) && (sample_in <  threshold);
  assign trig_hit = (st == S_ARMED) && sample_valid &&
                    (force_trig || (trig_falling ? fall_hit : rise_hit));

  // A fetch refills the output slot whenever it is empty or being drained this cycle.
  assign rd_xfer  = rd_valid && rd_ready;
  assign rd_fetch = (st == S_READOUT) && !ro_wait && (rd_cnt != RD_TOTAL) &&
                    (!rd_valid || rd_ready);

  // Sample buffer write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // Synchronous read register doubles as rd_data; it only advances on a fetch so stalls hold it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_fetch) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // Control FSM: capture counters, trigger pointer and the readout handshake registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= S_IDLE;
      wr_ptr   <= '0;
      trig_ptr <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      prev     <= '0;
      prev_ok  <= 1'b0;
      ro_wait  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (wr_en) begin
        wr_ptr  <= wr_ptr + 1'b1;
        prev    <= sample_in;
        prev_ok <= 1'b1;
      end

      if (abort) begin
        st       <= S_IDLE;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
        ro_wait  <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            if (arm) begin
              wr_ptr   <= '0;
              fill_cnt <= '0;
              prev_ok  <= 1'b0;
              st       <= S_PREFILL;
            end
          end

          S_PREFILL: begin
            if (wr_en) begin
              fill_cnt <= fill_cnt + 1'b1;
              if (fill_cnt == PRE_LAST) begin
                st <= S_ARMED;
              end
            end
          end

          S_ARMED: begin
            if (trig_hit) begin
              trig_ptr <= wr_ptr;
              post_cnt <= '0;
              st       <= S_POST;
            end
          end

          S_POST: begin
            if (wr_en) begin
              post_cnt <= post_cnt + 1'b1;
              if (post_cnt == POST_LAST) begin
                // Record starts PRETRIG samples before the trigger, wrapping mod DEPTH.
                rd_ptr  <= trig_ptr - PRE_OFS;
                rd_cnt  <= '0;
                ro_wait <= 1'b1;
                st      <= S_READOUT;
              end
            end
          end

          S_READOUT: begin
            // One idle cycle on entry, so the first sample appears two cycles in.
            ro_wait <= 1'b0;
            if (rd_fetch) begin
              rd_ptr   <= rd_ptr + 1'b1;
              rd_cnt   <= rd_cnt + 1'b1;
              rd_valid <= 1'b1;
              rd_last  <= (rd_cnt == RD_LAST);
            end else if (rd_xfer) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end
            if (rd_xfer && rd_last) begin
              done <= 1'b1;
              st   <= S_IDLE;
            end
          end

          default: begin
            st <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
